// File: rtl/cond_pkg.sv
// Shared definitions for the conditional issue stage.
//   - 4-bit ARM condition codes (instruction bits [31:28])
//   - issue-stage FSM state type
//   - bit positions of N/Z/C/V inside a packed {N,Z,C,V} flag vector
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_EVAL,
    ST_VALID
  } state_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator.
//   cond  [3:0] : condition field of the instruction
//   flags [3:0] : {N,Z,C,V}
//   pass        : 1 when the instruction should execute
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c & !z;
      COND_LS: pass = !c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_issue_stage.sv
// Decode->execute issue stage that gates each instruction on its ARM cond field.
// Ports:
//   clk, reset_n (sync, active-low), flush (kills held instruction)
//   in_valid/in_ready/in_instr/in_sets_flags   : upstream handshake
//   flag_c/z/n/v                                : architectural flags
//   fwd_valid/fwd_flags {N,Z,C,V}               : newest in-flight writer's flags
//   fr_ld                                       : flag register load, retires one writer
//   out_valid/out_ready/out_instr/out_exec/out_sets_flags : downstream handshake
//   pending                                     : in-flight flag writers
module cond_issue_stage
  import cond_pkg::*;
#(
  parameter  int unsigned MAX_PEND = 3,
  localparam int unsigned CW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic          in_sets_flags,
  input  logic          flag_c,
  input  logic          flag_z,
  input  logic          flag_n,
  input  logic          flag_v,
  input  logic          fwd_valid,
  input  logic [3:0]    fwd_flags,
  input  logic          fr_ld,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic          out_exec,
  output logic          out_sets_flags,
  output logic [CW-1:0] pending
);

  localparam logic [CW-1:0] PEND_MAX = CW'(MAX_PEND);
  localparam logic [CW-1:0] PEND_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic          sets_q, sets_d;
  logic          exec_q, exec_d;
  logic          osf_q, osf_d;
  logic [CW-1:0] pending_q, pending_d;

  logic [3:0] flags_sel;
  logic       flag_free, resolved, pass, sat, accept, handoff, inc;

  cond_eval u_cond_eval (
    .cond  (instr_q[31:28]),
    .flags (flags_sel),
    .pass  (pass)
  );

  always_comb begin
    flag_free = (instr_q[31:28] == COND_AL) || (instr_q[31:28] == COND_NV);
    flags_sel = {flag_n, flag_z, flag_c, flag_v};
    resolved  = 1'b1;
    if (pending_q == '0) begin
      flags_sel = {flag_n, flag_z, flag_c, flag_v};
    end else if (pending_q == PEND_ONE && fwd_valid) begin
      flags_sel = fwd_flags;
    end else begin
      resolved = flag_free;
    end
    sat      = sets_q && pass && (pending_q == PEND_MAX);
    in_ready = reset_n && !flush &&
               (state_q == ST_EMPTY || (state_q == ST_VALID && out_ready));
    accept   = in_valid && in_ready;
    handoff  = (state_q == ST_VALID) && out_ready && !flush;
    inc      = handoff && osf_q;
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    sets_d  = sets_q;
    exec_d  = exec_q;
    osf_d   = osf_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          instr_d = in_instr;
          sets_d  = in_sets_flags;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (resolved && !sat) begin
          exec_d  = pass;
          osf_d   = sets_q && pass;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ready) begin
          if (accept) begin
            instr_d = in_instr;
            sets_d  = in_sets_flags;
            state_d = ST_EVAL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // flush overrides any handoff decided above
    if (flush) begin
      state_d = ST_EMPTY;
      exec_d  = 1'b0;
      osf_d   = 1'b0;
    end
  end

  // simultaneous handoff of a writer and a retire leaves the count unchanged
  always_comb begin
    pending_d = pending_q;
    if (inc && !fr_ld && pending_q != PEND_MAX) begin
      pending_d = pending_q + PEND_ONE;
    end else if (!inc && fr_ld && pending_q != '0) begin
      pending_d = pending_q - PEND_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      instr_q   <= '0;
      sets_q    <= 1'b0;
      exec_q    <= 1'b0;
      osf_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      sets_q    <= sets_d;
      exec_q    <= exec_d;
      osf_q     <= osf_d;
      pending_q <= pending_d;
    end
  end

  assign out_valid      = (state_q == ST_VALID);
  assign out_instr      = instr_q;
  assign out_exec       = exec_q;
  assign out_sets_flags = osf_q;
  assign pending        = pending_q;

endmodule

// File: tb/tb_cond_issue_stage.sv
module tb_cond_issue_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, in_sets_flags;
  logic [31:0] in_instr, out_instr;
  logic        flag_c, flag_z, flag_n, flag_v, fwd_valid, fr_ld;
  logic [3:0]  fwd_flags;
  logic        out_valid, out_ready, out_exec, out_sets_flags;
  logic [1:0]  pending;

  int checks = 0;
  int passes = 0;
  int model_pend = 0;

  always #5 clk = ~clk;

  cond_issue_stage #(.MAX_PEND(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_sets_flags(in_sets_flags),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .fwd_valid(fwd_valid), .fwd_flags(fwd_flags), .fr_ld(fr_ld),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_exec(out_exec), .out_sets_flags(out_sets_flags), .pending(pending)
  );

  // Reference: pairs of codes share a base predicate, odd code negates it.
  function automatic bit ref_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b0;
    if (cond == 4'hE) return 1'b1;
    return cond[0] ? !base : base;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic s);
    in_instr = ins; in_sets_flags = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (pending !== 2'd0) $display("FAIL reset_pending got=%0d exp=0", pending); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passes++;
    reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got=%b exp=1", in_ready); else passes++;
  endtask

  task automatic test_eq();
    {flag_n, flag_z, flag_c, flag_v} = 4'b0100;
    issue(32'h0000_0000, 1'b0);
    checks++; if (out_valid !== 1'b0) $display("FAIL eq_eval_valid got=%b exp=0", out_valid); else passes++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL eq_latency got=%b exp=1", out_valid); else passes++;
    checks++; if (out_exec !== 1'b1) $display("FAIL eq_z1_exec got=%b exp=1", out_exec); else passes++;
    handoff();
    flag_z = 1'b0;
    issue(32'h0000_0000, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL eq2_valid got=%b exp=1", out_valid); else passes++;
    checks++; if (out_exec !== 1'b0) $display("FAIL eq_z0_exec got=%b exp=0", out_exec); else passes++;
    handoff();
  endtask

  task automatic test_forward();
    issue(32'hE090_0001, 1'b1);
    tick();
    handoff();
    checks++; if (pending !== 2'd1) $display("FAIL fwd_pending got=%0d exp=1", pending); else passes++;
    issue(32'h1000_0000, 1'b0);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL fwd_stall got=%b exp=0", out_valid); else passes++;
    fwd_valid = 1'b1; fwd_flags = 4'b0000;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL fwd_release got=%b exp=1", out_valid); else passes++;
    checks++; if (out_exec !== 1'b1) $display("FAIL fwd_ne_exec got=%b exp=1", out_exec); else passes++;
    handoff();
    fwd_valid = 1'b0;
  endtask

  task automatic test_pending_cancel();
    issue(32'hE090_0001, 1'b1);
    tick();
    out_ready = 1'b1; fr_ld = 1'b1;
    tick();
    out_ready = 1'b0; fr_ld = 1'b0;
    checks++; if (pending !== 2'd1) $display("FAIL cancel_pending got=%0d exp=1", pending); else passes++;
    fr_ld = 1'b1;
    tick();
    checks++; if (pending !== 2'd0) $display("FAIL retire_pending got=%0d exp=0", pending); else passes++;
    tick();
    fr_ld = 1'b0;
    checks++; if (pending !== 2'd0) $display("FAIL retire_at_zero got=%0d exp=0", pending); else passes++;
  endtask

  task automatic test_sat();
    for (int i = 0; i < 3; i++) begin
      issue(32'hE090_0001, 1'b1);
      tick();
      handoff();
    end
    checks++; if (pending !== 2'd3) $display("FAIL sat_fill got=%0d exp=3", pending); else passes++;
    issue(32'hE090_0002, 1'b1);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL sat_wait got=%b exp=0", out_valid); else passes++;
    fr_ld = 1'b1;
    tick();
    fr_ld = 1'b0;
    checks++; if (pending !== 2'd2) $display("FAIL sat_retire got=%0d exp=2", pending); else passes++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL sat_proceed got=%b exp=1", out_valid); else passes++;
    handoff();
    checks++; if (pending !== 2'd3) $display("FAIL sat_refill got=%0d exp=3", pending); else passes++;
    fr_ld = 1'b1;
    repeat (3) tick();
    fr_ld = 1'b0;
    checks++; if (pending !== 2'd0) $display("FAIL sat_drain got=%0d exp=0", pending); else passes++;
  endtask

  task automatic test_flush_ls();
    issue(32'hE090_0001, 1'b1);
    tick();
    out_ready = 1'b1; flush = 1'b1;
    tick();
    out_ready = 1'b0; flush = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (pending !== 2'd0) $display("FAIL flush_pending got=%0d exp=0", pending); else passes++;
    {flag_n, flag_z, flag_c, flag_v} = 4'b0010;
    issue(32'h9000_0000, 1'b0);
    tick();
    checks++; if (out_exec !== 1'b0) $display("FAIL ls_c1_exec got=%b exp=0", out_exec); else passes++;
    handoff();
    flag_c = 1'b0;
    issue(32'h9000_0000, 1'b0);
    tick();
    checks++; if (out_exec !== 1'b1) $display("FAIL ls_c0_exec got=%b exp=1", out_exec); else passes++;
    handoff();
    issue(32'hF000_0000, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL nv_valid got=%b exp=1", out_valid); else passes++;
    checks++; if (out_exec !== 1'b0) $display("FAIL nv_exec got=%b exp=0", out_exec); else passes++;
    handoff();
  endtask

  task automatic test_random();
    model_pend = 0;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] ins;
      logic        s, exp_exec, fr;
      logic [3:0]  arch, fwd, eff;
      int          w;
      while (model_pend > 1) begin
        fr_ld = 1'b1; tick(); fr_ld = 1'b0;
        model_pend--;
      end
      ins  = $urandom;
      s    = 1'($urandom_range(0, 1));
      arch = 4'($urandom);
      fwd  = 4'($urandom);
      {flag_n, flag_z, flag_c, flag_v} = arch;
      fwd_flags = fwd;
      fwd_valid = (model_pend == 1);
      eff = (model_pend == 0) ? arch : fwd;
      exp_exec = ref_pass(ins[31:28], eff);
      issue(ins, s);
      w = 0;
      while (!out_valid && w < 10) begin tick(); w++; end
      checks++; if (out_valid !== 1'b1) $display("FAIL rnd_timeout t=%0d got=%b exp=1", t, out_valid); else passes++;
      repeat ($urandom_range(0, 2)) tick();
      checks++; if (out_instr !== ins) $display("FAIL rnd_instr t=%0d got=%h exp=%h", t, out_instr, ins); else passes++;
      checks++; if (out_exec !== exp_exec) $display("FAIL rnd_exec t=%0d cond=%h got=%b exp=%b", t, ins[31:28], out_exec, exp_exec); else passes++;
      checks++; if (out_sets_flags !== (s & exp_exec)) $display("FAIL rnd_sets t=%0d got=%b exp=%b", t, out_sets_flags, s & exp_exec); else passes++;
      fr = 1'($urandom_range(0, 1));
      fr_ld = fr;
      handoff();
      fr_ld = 1'b0;
      fwd_valid = 1'b0;
      if (s && exp_exec && fr) begin
        model_pend = model_pend;
      end else if (s && exp_exec) begin
        model_pend = (model_pend < 3) ? model_pend + 1 : 3;
      end else if (fr && model_pend > 0) begin
        model_pend--;
      end
      checks++; if (pending !== 2'(model_pend)) $display("FAIL rnd_pending t=%0d got=%0d exp=%0d", t, pending, model_pend); else passes++;
    end
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_sets_flags = 1'b0;
    {flag_n, flag_z, flag_c, flag_v} = 4'b0000;
    fwd_valid = 1'b0; fwd_flags = '0; fr_ld = 1'b0; out_ready = 1'b0;
    test_reset();
    test_eq();
    test_forward();
    test_pending_cancel();
    test_sat();
    test_flush_ls();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
